// File: rtl/sys_ctrl_sync_pkg.sv
// Shared constants, reset-sequencer state type and a width helper
// for the system reset / input conditioning block.
package sys_ctrl_sync_pkg;

    localparam int unsigned CLOCK_FREQUENCY           = 32_000_000;
    // 1 ms of stable input at the system clock rate
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = CLOCK_FREQUENCY / 1000;
    localparam int unsigned DEFAULT_RESET_HOLD_CYCLES = 64;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } rst_state_t;

    // Number of bits needed to hold values 0..value-1 (minimum 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/sys_ctrl_sync_sync_debounce.sv
// One input channel: synchroniser chain, debounce counter, accepted
// level and one-cycle rise/fall strobes (masked while suppress=1).
module sync_debounce
    import sys_ctrl_sync_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic        RESET_VAL       = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic in_raw,
    input  logic suppress,
    output logic in_level,
    output logic in_rise,
    output logic in_fall
);

    localparam int unsigned      CW       = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s_in;

    assign s_in = sync_q[SYNC_STAGES-1];

    // Shift the raw pad value through the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_raw};
    end

    // Count consecutive cycles of disagreement; accept after DEBOUNCE_CYCLES.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s_in != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s_in;
                rise_d  = s_in;
                fall_d  = ~s_in;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Channel state registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Masking at the output keeps strobes low for every cycle sys_reset is high,
    // including a strobe registered in the same edge that re-asserts reset.
    assign in_level = level_q;
    assign in_rise  = rise_q & ~suppress;
    assign in_fall  = fall_q & ~suppress;

endmodule

// File: rtl/sys_ctrl_sync.sv
// Reset sequencer (lock-gated, stretched system reset) plus NCH
// synchronised and debounced input channels.
module sys_ctrl_sync
    import sys_ctrl_sync_pkg::*;
#(
    parameter int unsigned    NCH               = 2,
    parameter int unsigned    SYNC_STAGES       = 2,
    parameter int unsigned    DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned    RESET_HOLD_CYCLES = DEFAULT_RESET_HOLD_CYCLES,
    parameter logic [NCH-1:0] RESET_LEVEL       = '0
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           locked,
    input  logic [NCH-1:0] in_raw,
    output logic [NCH-1:0] in_level,
    output logic [NCH-1:0] in_rise,
    output logic [NCH-1:0] in_fall,
    output logic           sys_reset,
    output logic           reset_led
);

    localparam int unsigned   HW        = clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic                   s_lock;
    rst_state_t             state_q, state_d;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
    logic                   sys_reset_q, sys_reset_d;

    assign s_lock = lock_sync_q[SYNC_STAGES-1];

    // Shift DCM locked through its synchroniser chain.
    always_comb begin
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], locked};
    end

    // Next-state logic: hold reset until lock has been stable long enough.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        sys_reset_d = sys_reset_q;
        case (state_q)
            ST_HOLD: begin
                sys_reset_d = 1'b1;
                if (!s_lock) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = ST_RUN;
                    hold_cnt_d  = '0;
                    sys_reset_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            ST_RUN: begin
                sys_reset_d = 1'b0;
                if (!s_lock) begin
                    state_d     = ST_HOLD;
                    hold_cnt_d  = '0;
                    sys_reset_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_HOLD;
                hold_cnt_d  = '0;
                sys_reset_d = 1'b1;
            end
        endcase
    end

    // Sequencer registers: reset asserts sys_reset asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_sync_q <= '0;
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            sys_reset_q <= 1'b1;
        end else begin
            lock_sync_q <= lock_sync_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            sys_reset_q <= sys_reset_d;
        end
    end

    assign sys_reset = sys_reset_q;
    assign reset_led = sys_reset_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        sync_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_LEVEL[i])
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .in_raw   (in_raw[i]),
            .suppress (sys_reset_q),
            .in_level (in_level[i]),
            .in_rise  (in_rise[i]),
            .in_fall  (in_fall[i])
        );
    end

endmodule

// File: tb/tb_sys_ctrl_sync.sv
// Self-checking bench for sys_ctrl_sync (NCH=2, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=8, RESET_HOLD_CYCLES=64).
module tb_sys_ctrl_sync;

    logic       clock;
    logic       reset;
    logic       locked;
    logic [1:0] in_raw;
    logic [1:0] in_level;
    logic [1:0] in_rise;
    logic [1:0] in_fall;
    logic       sys_reset;
    logic       reset_led;

    logic [7:0] obs;
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int unsigned n_cmp;
    int unsigned n_bad;

    sys_ctrl_sync #(
        .NCH               (2),
        .SYNC_STAGES       (2),
        .DEBOUNCE_CYCLES   (8),
        .RESET_HOLD_CYCLES (64),
        .RESET_LEVEL       (2'b00)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .locked    (locked),
        .in_raw    (in_raw),
        .in_level  (in_level),
        .in_rise   (in_rise),
        .in_fall   (in_fall),
        .sys_reset (sys_reset),
        .reset_led (reset_led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign obs = {sys_reset, reset_led, in_level, in_rise, in_fall};

    function automatic logic [7:0] mk(input logic sr, input logic [1:0] lvl,
                                      input logic [1:0] r, input logic [1:0] f);
        return {sr, sr, lvl, r, f};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        locked = 1'b1;
        in_raw = 2'b00;
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (obs !== mk(1'b1, 2'b00, 2'b00, 2'b00)) begin
            n_bad++;
            $display("FAIL reset_async: got %b expected %b", obs, mk(1'b1, 2'b00, 2'b00, 2'b00));
        end
        for (int k = 1; k <= 5; k++) exp_q.push_back(mk(1'b1, 2'b00, 2'b00, 2'b00));
        for (int k = 1; k <= 5; k++) begin
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reset_hold: cycle %0d got %b expected %b", k, obs, e);
            end
        end
        // release: sys_reset must fall at exactly edge 66
        for (int k = 1; k <= 70; k++) exp_q.push_back(mk(k <= 65, 2'b00, 2'b00, 2'b00));
        reset = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL power_up: cycle %0d got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic test_lock_loss();
        for (int k = 1; k <= 72; k++)
            exp_q.push_back(mk((k >= 3) && (k <= 68), 2'b00, 2'b00, 2'b00));
        locked = 1'b0;
        for (int k = 1; k <= 72; k++) begin
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL lock_loss: cycle %0d got %b expected %b", k, obs, e);
            end
            if (k == 3) locked = 1'b1;
        end
    endtask

    task automatic test_debounce_accept();
        for (int k = 1; k <= 14; k++)
            exp_q.push_back(mk(1'b0, (k >= 10) ? 2'b01 : 2'b00,
                               (k == 10) ? 2'b01 : 2'b00, 2'b00));
        in_raw[0] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL debounce_accept: cycle %0d got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic test_glitch_reject();
        // 7-cycle glitch: ignored
        for (int k = 1; k <= 20; k++) exp_q.push_back(mk(1'b0, 2'b01, 2'b00, 2'b00));
        in_raw[1] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL glitch_7: cycle %0d got %b expected %b", k, obs, e);
            end
            if (k == 7) in_raw[1] = 1'b0;
        end
        // 8-cycle pulse: accepted rise at 10, then the low is accepted at 18
        for (int k = 1; k <= 21; k++)
            exp_q.push_back(mk(1'b0, {((k >= 10) && (k <= 17)), 1'b1},
                               (k == 10) ? 2'b10 : 2'b00,
                               (k == 18) ? 2'b10 : 2'b00));
        in_raw[1] = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL glitch_8: cycle %0d got %b expected %b", k, obs, e);
            end
            if (k == 8) in_raw[1] = 1'b0;
        end
    endtask

    task automatic test_suppression();
        for (int k = 1; k <= 82; k++)
            exp_q.push_back(mk((k >= 3) && (k <= 78), (k >= 13) ? 2'b00 : 2'b01,
                               2'b00, 2'b00));
        locked = 1'b0;
        for (int k = 1; k <= 82; k++) begin
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL suppression: cycle %0d got %b expected %b", k, obs, e);
            end
            if (k == 3)  in_raw[0] = 1'b0;
            if (k == 13) locked = 1'b1;
        end
    endtask

    task automatic test_async_reset_mid_debounce();
        // channel 1 accepted high first so reset has a visible level to clear
        for (int k = 1; k <= 11; k++)
            exp_q.push_back(mk(1'b0, (k >= 10) ? 2'b10 : 2'b00,
                               (k == 10) ? 2'b10 : 2'b00, 2'b00));
        in_raw[1] = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL mid_reset_setup: cycle %0d got %b expected %b", k, obs, e);
            end
        end
        // channel 0 counts up to 5 after 7 edges
        for (int k = 1; k <= 7; k++) exp_q.push_back(mk(1'b0, 2'b10, 2'b00, 2'b00));
        in_raw[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL mid_reset_count: cycle %0d got %b expected %b", k, obs, e);
            end
        end
        #3 reset = 1'b1;
        #1;
        n_cmp++;
        if (obs !== mk(1'b1, 2'b00, 2'b00, 2'b00)) begin
            n_bad++;
            $display("FAIL mid_reset_async: got %b expected %b", obs, mk(1'b1, 2'b00, 2'b00, 2'b00));
        end
        for (int k = 1; k <= 2; k++) exp_q.push_back(mk(1'b1, 2'b00, 2'b00, 2'b00));
        for (int k = 1; k <= 2; k++) begin
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL mid_reset_held: cycle %0d got %b expected %b", k, obs, e);
            end
        end
        // both channels re-qualify from scratch; edges masked during sys_reset
        for (int k = 1; k <= 68; k++)
            exp_q.push_back(mk(k <= 65, (k >= 10) ? 2'b11 : 2'b00, 2'b00, 2'b00));
        reset = 1'b0;
        for (int k = 1; k <= 68; k++) begin
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL mid_reset_release: cycle %0d got %b expected %b", k, obs, e);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_lock_loss();
        test_debounce_accept();
        test_glitch_reject();
        test_suppression();
        test_async_reset_mid_debounce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sys_ctrl_sync.md
Name: sys_ctrl_sync

Overview:
Parametrised reset sequencer and multi-channel input conditioner for board top levels. It replaces ad-hoc per-signal two-flop registers (reset, UART rewind, buttons) with one block that does three things: metastability-safe synchronisation, per-channel debounce with edge strobes, and a lock-gated, stretched system reset. It sits between the pads/DCM and the core (generator), clocked by the BUFG'd system clock.

Parameters:
NCH, 2, number of conditioned input channels (1..16)
SYNC_STAGES, 2, synchroniser flop depth for inputs and locked (2..4)
DEBOUNCE_CYCLES, 32000, consecutive stable cycles required to accept a new level (>=1; 1 ms at 32 MHz)
RESET_HOLD_CYCLES, 64, cycles locked must stay high before sys_reset deasserts (>=1)
RESET_LEVEL, {NCH{1'b0}}, per-channel reset value of in_level

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset (raw pad, not yet synchronised)
locked  input  1  DCM LOCKED, asynchronous to clock
in_raw  input  NCH  raw asynchronous pad inputs
in_level  output  NCH  debounced level
in_rise  output  NCH  one-cycle pulse on accepted 0->1 transition
in_fall  output  NCH  one-cycle pulse on accepted 1->0 transition
sys_reset  output  1  core reset: asserts asynchronously, deasserts synchronously
reset_led  output  1  mirror of sys_reset for a board LED

Behaviour:
- Reset values: in_level=RESET_LEVEL, in_rise=in_fall=0, sys_reset=1, reset_led=1, all synchroniser flops and counters 0.
- Synchronisers: SYNC_STAGES flops per in_raw bit and for locked; outputs are s_in and s_lock. Latency from a pad change to s_* is SYNC_STAGES cycles.
- Reset sequencer FSM, states HOLD and RUN:
  - HOLD: sys_reset=1. hold_cnt increments while s_lock=1 and clears to 0 when s_lock=0. When hold_cnt==RESET_HOLD_CYCLES-1 and s_lock=1, go to RUN on the next edge, where sys_reset=0.
  - RUN: sys_reset=0. If s_lock=0, go to HOLD: sys_reset=1 the next cycle and hold_cnt=0.
  - Asserting reset forces HOLD and sys_reset=1 immediately (asynchronous), from any state.
  - Deassertion timing: with locked steady high, sys_reset falls exactly SYNC_STAGES+RESET_HOLD_CYCLES rising edges after reset falls.
- Debounce, per channel, independent of the FSM:
  - cnt clears whenever s_in==in_level. Otherwise cnt increments.
  - When cnt==DEBOUNCE_CYCLES-1 and s_in!=in_level: in_level<=s_in, cnt<=0, and the matching rise/fall pulse is high for exactly that following cycle.
  - A glitch shorter than DEBOUNCE_CYCLES cycles, measured after synchronisation, is ignored and its count is discarded.
  - Counter width is clog2(DEBOUNCE_CYCLES+1). It never wraps because it clears on acceptance.
- Edge suppression: in_rise/in_fall are forced to 0 while sys_reset=1. in_level still tracks, so the core sees a correct level on reset release but no spurious edge.
- Simultaneous events:
  - reset asserted in the same cycle as an accepted edge: the reset wins and all outputs take their reset values.
  - s_lock drop in the same cycle hold_cnt reaches terminal: stay in HOLD and clear the counter.
- Mid-operation reset: all channel counters are lost. After release, each channel re-qualifies from RESET_LEVEL.
- Combinational paths: none from in_raw, locked or reset to any output. The single exception is the asynchronous assertion path from reset to sys_reset.

Decomposition:
- Shared header (sys_ctrl_defs.vh): CLOCK_FREQUENCY define reuse, a clog2 constant function, and the default debounce/hold constants.
- One sub-module, sync_debounce (one channel: synchroniser, counter, level, edge detect), instantiated NCH times by a generate loop.
- The reset FSM and locked synchroniser live in sys_ctrl_sync.

Test Plan:
- Power-up: reset=1 for 5 cycles, locked=1 throughout, defaults (SYNC_STAGES=2, RESET_HOLD_CYCLES=64) -> sys_reset=1 until exactly 66 edges after reset falls, then 0; reset_led equals sys_reset.
- Lock loss: in RUN, drop locked for 3 cycles -> sys_reset=1 starting 3 cycles after the drop (2 sync + 1 FSM); it falls again 66 cycles after locked returns.
- Debounce accept (DEBOUNCE_CYCLES=8 override): in_raw[0] 0->1 steady -> in_level[0]=1 and in_rise[0]=1 for one cycle, 2+8 cycles after the change; in_fall stays 0.
- Glitch reject: in_raw[1] high for 7 cycles then low (DEBOUNCE_CYCLES=8) -> in_level[1] stays 0, no pulses; high for 8 cycles -> accepted.
- Suppression: change in_raw[0] while sys_reset=1 -> in_level updates, in_rise/in_fall remain 0; no pulse on release.
- Async reset mid-debounce: assert reset between edges with cnt=5 -> sys_reset, in_level=RESET_LEVEL, pulses 0 immediately; after release the channel needs a full 8 fresh cycles.
